// File: rtl/shift_left_ctrl_if.sv
`default_nettype none
// ============================================================================
//  Module   : shift_left_ctrl_if
//  Purpose  : Word-producer handshake bundle for shift_left_ctrl.
//  Signals  : in_data  [W-1:0] parallel word to serialise (producer -> ctrl)
//             in_valid          in_data is valid         (producer -> ctrl)
//             in_ready          ctrl accepts this cycle  (ctrl -> producer)
//  Modports : master = word producer, slave = shift_left_ctrl
//  Revision : 1.0 - initial release
// ============================================================================
interface shift_left_ctrl_if #(
  parameter int W = 8
);
  logic [W-1:0] in_data;
  logic         in_valid;
  logic         in_ready;

  modport master (
    output in_data,
    output in_valid,
    input  in_ready
  );

  modport slave (
    input  in_data,
    input  in_valid,
    output in_ready
  );
endinterface
`default_nettype wire

// File: rtl/shift_left_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : shift_left_ctrl
//  Purpose  : Sequencer for an external W-bit parallel-load shift-left
//             register. Accepts words over valid/ready, drives the register
//             load controls and frames the MSB-first serial stream taken from
//             the register's top bit.
//  Ports    : clk         rising-edge clock (shared with the shift register)
//             rst_n       asynchronous active-low reset
//             in_if       word handshake (slave side: data/valid in, ready out)
//             i_flush     synchronous abort, returns to IDLE
//             o_sl_pl_n   register PL (0 = load next edge, 1 = shift left)
//             o_sl_din    register parallel data
//             i_sl_msb    register top bit D[W-1]
//             o_ser_bit   serial data (0 unless o_ser_valid)
//             o_ser_valid live frame bit this cycle
//             o_ser_last  final (LSB) bit of the frame
//             o_busy      controller not idle
//             o_done      one-cycle pulse after the last bit
//  Revision : 1.0 - initial release
// ============================================================================
module shift_left_ctrl #(
  parameter int W     = 8,
  parameter int CNT_W = 3
) (
  input  wire          clk,
  input  wire          rst_n,
  shift_left_ctrl_if.slave in_if,
  input  wire          i_flush,
  output logic         o_sl_pl_n,
  output logic [W-1:0] o_sl_din,
  input  wire          i_sl_msb,
  output logic         o_ser_bit,
  output logic         o_ser_valid,
  output logic         o_ser_last,
  output logic         o_busy,
  output logic         o_done
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    SHIFT = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] c_LAST = CNT_W'(W - 1);

  state_t           r_state;
  state_t           w_state_nxt;
  logic [CNT_W-1:0] r_cnt;
  logic [W-1:0]     r_din;
  logic             r_done;
  logic             w_last;
  logic             w_ready;
  logic             w_accept;

  // Ready is a function of state and flush only, never of in_valid.
  // In the last SHIFT cycle the next word may be taken so the following
  // frame starts after a single LOAD gap cycle.
  always_comb begin
    w_last      = (r_state == SHIFT) && (r_cnt == c_LAST);
    w_ready     = ((r_state == IDLE) || w_last) && !i_flush;
    w_accept    = w_ready && in_if.in_valid;
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (w_accept) w_state_nxt = LOAD;
      LOAD:    w_state_nxt = SHIFT;
      SHIFT:   if (w_last) w_state_nxt = w_accept ? LOAD : IDLE;
      default: w_state_nxt = IDLE;
    endcase
    // Flush overrides everything, including an accept in the same cycle.
    if (i_flush) w_state_nxt = IDLE;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_din   <= '0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      // Counter only advances inside a frame; it is cleared on the final
      // bit, on flush and outside SHIFT so every frame starts at zero.
      if (i_flush || (r_state != SHIFT) || w_last) r_cnt <= '0;
      else                                          r_cnt <= r_cnt + CNT_W'(1);
      if (w_accept) r_din <= in_if.in_data;
      r_done <= w_last && !i_flush;
    end
  end

  assign in_if.in_ready = w_ready;
  assign o_sl_pl_n      = (r_state != LOAD);
  assign o_sl_din       = r_din;
  assign o_ser_valid    = (r_state == SHIFT);
  assign o_ser_bit      = (r_state == SHIFT) && i_sl_msb;
  assign o_ser_last     = w_last;
  assign o_busy         = (r_state != IDLE);
  assign o_done         = r_done;

endmodule
`default_nettype wire

// File: tb/tb_shift_left_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_shift_left_ctrl
//  Purpose  : Directed self-checking bench for shift_left_ctrl, including a
//             behavioural model of the external shift-left register.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_shift_left_ctrl;

  localparam int W = 8;

  logic         clk;
  logic         rst_n;
  logic         flush;
  logic         sl_pl_n;
  logic [W-1:0] sl_din;
  logic         ser_bit;
  logic         ser_valid;
  logic         ser_last;
  logic         busy;
  logic         done;
  logic [W-1:0] sreg;

  int n_assert;
  int n_fail;

  shift_left_ctrl_if #(.W(W)) ifc ();

  shift_left_ctrl #(.W(W), .CNT_W(3)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_if       (ifc),
    .i_flush     (flush),
    .o_sl_pl_n   (sl_pl_n),
    .o_sl_din    (sl_din),
    .i_sl_msb    (sreg[W-1]),
    .o_ser_bit   (ser_bit),
    .o_ser_valid (ser_valid),
    .o_ser_last  (ser_last),
    .o_busy      (busy),
    .o_done      (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // External parallel-load shift-left register.
  initial sreg = '0;
  always @(posedge clk) begin
    if (!sl_pl_n) sreg <= sl_din;
    else          sreg <= {sreg[W-2:0], 1'b0};
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Walk n SHIFT cycles of a frame carrying word w, checking each bit.
  task automatic run_bits(input logic [W-1:0] w, input int n);
    for (int k = 0; k < n; k++) begin
      tick();
      chk("ser_valid", ser_valid, 1);
      chk("ser_bit",   ser_bit,   w[W-1-k]);
      chk("ser_last",  ser_last,  (k == W-1));
      chk("in_ready",  ifc.in_ready, (k == W-1));
      chk("sl_pl_n_sh", sl_pl_n, 1);
      chk("done_sh",   done,      0);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_busy"},      busy,      0);
    chk({tag, "_sl_pl_n"},   sl_pl_n,   1);
    chk({tag, "_sl_din"},    sl_din,    0);
    chk({tag, "_ser_valid"}, ser_valid, 0);
    chk({tag, "_ser_last"},  ser_last,  0);
    chk({tag, "_ser_bit"},   ser_bit,   0);
    chk({tag, "_done"},      done,      0);
  endtask

  initial begin
    n_assert     = 0;
    n_fail       = 0;
    rst_n        = 1'b0;
    flush        = 1'b0;
    ifc.in_valid = 1'b0;
    ifc.in_data  = '0;

    // ---------------- reset ----------------
    #2;
    check_reset_outputs("rst");
    tick();
    tick();
    rst_n = 1'b1;
    tick();
    chk("rel_in_ready", ifc.in_ready, 1);
    chk("rel_busy",     busy,         0);

    // ---------------- single word 01100101 ----------------
    ifc.in_data  = 8'b0110_0101;
    ifc.in_valid = 1'b1;
    tick();
    chk("load_pl_n",  sl_pl_n,      0);
    chk("load_din",   sl_din,       8'h65);
    chk("load_ready", ifc.in_ready, 0);
    chk("load_busy",  busy,         1);
    chk("load_valid", ser_valid,    0);
    ifc.in_valid = 1'b0;
    run_bits(8'b0110_0101, W);
    tick();
    chk("sw_done",  done,      1);
    chk("sw_valid", ser_valid, 0);
    chk("sw_busy",  busy,      0);
    tick();
    chk("sw_done_clr", done,      0);
    chk("sw_idle_val", ser_valid, 0);

    // ---------------- back-to-back A5 then 3C ----------------
    ifc.in_data  = 8'hA5;
    ifc.in_valid = 1'b1;
    tick();
    chk("b2b_load1", sl_pl_n, 0);
    ifc.in_data = 8'h3C;
    run_bits(8'hA5, W);
    tick();
    chk("b2b_gap_pl_n", sl_pl_n,   0);
    chk("b2b_gap_din",  sl_din,    8'h3C);
    chk("b2b_gap_done", done,      1);
    chk("b2b_gap_val",  ser_valid, 0);
    ifc.in_valid = 1'b0;
    run_bits(8'h3C, W);
    tick();
    chk("b2b_done", done, 1);
    chk("b2b_busy", busy, 0);

    // ---------------- flush at cnt=3 ----------------
    ifc.in_data  = 8'hFF;
    ifc.in_valid = 1'b1;
    tick();
    ifc.in_valid = 1'b0;
    run_bits(8'hFF, 4);
    flush        = 1'b1;
    ifc.in_valid = 1'b1;
    ifc.in_data  = 8'h81;
    tick();
    flush        = 1'b0;
    ifc.in_valid = 1'b0;
    chk("fl_busy",  busy,      0);
    chk("fl_valid", ser_valid, 0);
    chk("fl_done",  done,      0);
    chk("fl_pl_n",  sl_pl_n,   1);
    tick();
    chk("fl_done2", done, 0);
    chk("fl_busy2", busy, 0);

    // flush while idle blocks the accept
    flush        = 1'b1;
    ifc.in_valid = 1'b1;
    ifc.in_data  = 8'h81;
    #1;
    chk("fl_idle_ready", ifc.in_ready, 0);
    tick();
    chk("fl_idle_busy", busy, 0);
    flush = 1'b0;
    #1;
    chk("fl_idle_ready2", ifc.in_ready, 1);
    tick();
    chk("w81_load", sl_pl_n, 0);
    chk("w81_din",  sl_din,  8'h81);
    ifc.in_valid = 1'b0;
    run_bits(8'h81, W);
    tick();
    chk("w81_done", done, 1);

    // ---------------- async reset at cnt=5 ----------------
    ifc.in_data  = 8'hAA;
    ifc.in_valid = 1'b1;
    tick();
    ifc.in_valid = 1'b0;
    run_bits(8'hAA, 6);
    #2;
    rst_n = 1'b0;
    #1;
    check_reset_outputs("mid_rst");
    tick();
    rst_n = 1'b1;
    tick();
    chk("mr_done",  done,         0);
    chk("mr_ready", ifc.in_ready, 1);
    chk("mr_busy",  busy,         0);
    ifc.in_data  = 8'h0F;
    ifc.in_valid = 1'b1;
    tick();
    chk("w0f_load", sl_pl_n, 0);
    ifc.in_valid = 1'b0;
    run_bits(8'h0F, W);
    tick();
    chk("w0f_done", done, 1);
    chk("w0f_busy", busy, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
